// File: rtl/freq_sweep_pkg.sv
// Shared definitions for the frequency-sweep self-test.
//   state_t          sequencer states, also visible on the debug port
//   HALF_TABLE       generator half-periods, entry k at byte k
//   COUNT_TOL        allowed +/- deviation of a gate count
//   half_of()        table lookup by step index
//   expected_count() rising edges expected in a gate window
//   count_fails()    tolerance check of a measured count
package freq_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_GATE   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int unsigned TABLE_LEN = 4;
  // Byte k holds the half-period of step k: {1, 2, 5, 10}.
  localparam logic [3:0][7:0] HALF_TABLE = {8'd10, 8'd5, 8'd2, 8'd1};
  localparam int unsigned COUNT_TOL = 1;

  function automatic logic [7:0] half_of(input int unsigned idx);
    logic [1:0] sel;
    sel = 2'(idx % TABLE_LEN);
    return HALF_TABLE[sel];
  endfunction

  // A half-period of 0 behaves as 1 in the generator, so mirror that here.
  function automatic int unsigned expected_count(input int unsigned gate,
                                                 input int unsigned half);
    int unsigned h;
    h = (half == 0) ? 1 : half;
    return gate / (2 * h);
  endfunction

  function automatic logic count_fails(input int unsigned cnt,
                                       input int unsigned exp_cnt);
    return (cnt > exp_cnt + COUNT_TOL) || (cnt + COUNT_TOL < exp_cnt);
  endfunction

endpackage

// File: rtl/freq_sweep_ctrl_gen.sv
// prog_freq_gen: programmable square-wave divider.
//   i_Clk, i_Reset  clock, synchronous active-high reset
//   i_En            1 = run; 0 = hold counter at 0 and force output low
//   i_Half          half-period in clock cycles (0 treated as 1)
//   o_Freq_Out      square wave, period 2*i_Half, 50% duty
module prog_freq_gen #(
  parameter int DIV_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_En,
  input  logic [DIV_W-1:0] i_Half,
  output logic             o_Freq_Out
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic [DIV_W-1:0] half_eff;

  assign half_eff = (i_Half == '0) ? DIV_W'(1) : i_Half;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (!i_En) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (cnt_q == half_eff - DIV_W'(1)) begin
      cnt_d = '0;
      out_d = ~out_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign o_Freq_Out = out_q;

endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: loopback frequency self-test sequencer.
// Steps the generator through HALF_TABLE, counts synchronised rising edges
// of i_Freq_In over a GATE_CYCLES window and grades each count.
//   i_Clk, i_Reset  clock, synchronous active-high reset (aborts any run)
//   i_Start         run request, looked at only in IDLE
//   i_Freq_In       asynchronous returned signal
//   o_Freq_Out      generated test frequency
//   o_Busy          high from LOAD through DONE
//   o_Step          current table index
//   o_Count         last completed gate count, o_Count_Valid pulses on update
//   o_Fail_Mask     bit k set when step k missed its expected count
//   o_Done          one-cycle pulse after the run ends
//   o_Pass          last run had an all-zero fail mask
//   o_Dbg_State     current sequencer state
// Handshake: o_Count_Valid and o_Done are single-cycle strobes with no
// back-pressure; o_Count, o_Fail_Mask and o_Pass are stable while they pulse.
module freq_sweep_ctrl
  import freq_sweep_pkg::*;
#(
  parameter int NUM_STEPS     = 4,
  parameter int GATE_CYCLES   = 25000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int DIV_W         = 8,
  localparam int STEP_W       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Start,
  input  logic                 i_Freq_In,
  output logic                 o_Freq_Out,
  output logic                 o_Busy,
  output logic [STEP_W-1:0]    o_Step,
  output logic [CNT_W-1:0]     o_Count,
  output logic                 o_Count_Valid,
  output logic [NUM_STEPS-1:0] o_Fail_Mask,
  output logic                 o_Done,
  output logic                 o_Pass,
  output state_t               o_Dbg_State
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 valid_q, valid_d;
  logic [NUM_STEPS-1:0] mask_q, mask_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 en_q, en_d;
  logic [DIV_W-1:0]     half_q, half_d;
  // [0],[1]: two-flop synchroniser; [2]: previous synchronised value.
  logic [2:0]           sync_q;
  logic                 rise;
  logic                 step_fail;

  assign rise = sync_q[1] & ~sync_q[2];
  // half_q still holds the current step's half-period during CHECK.
  assign step_fail = count_fails(32'(cnt_q), expected_count(GATE_CYCLES, 32'(half_q)));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    valid_d = 1'b0;
    mask_d  = mask_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    en_d    = en_q;
    half_d  = half_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          state_d = ST_LOAD;
          step_d  = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        half_d  = DIV_W'(half_of(32'(step_q)));
        en_d    = 1'b1;
        cnt_d   = '0;
        timer_d = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          timer_d = '0;
          state_d = ST_GATE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_GATE: begin
        if (rise && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        if (timer_q == TMR_W'(GATE_CYCLES - 1)) begin
          timer_d = '0;
          state_d = ST_CHECK;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_CHECK: begin
        count_d        = cnt_q;
        valid_d        = 1'b1;
        mask_d[step_q] = step_fail;
        // Stopping the generator here makes the next LOAD restart it at phase 0.
        en_d           = 1'b0;
        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
          state_d = ST_DONE;
        end else begin
          step_d  = step_q + STEP_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = ~|mask_q;
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      en_q    <= 1'b0;
      half_q  <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      en_q    <= en_d;
      half_q  <= half_d;
      sync_q  <= {sync_q[1:0], i_Freq_In};
    end
  end

  prog_freq_gen #(.DIV_W(DIV_W)) u_gen (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_En       (en_q),
    .i_Half     (half_q),
    .o_Freq_Out (o_Freq_Out)
  );

  assign o_Busy        = (state_q != ST_IDLE);
  assign o_Step        = step_q;
  assign o_Count       = count_q;
  assign o_Count_Valid = valid_q;
  assign o_Fail_Mask   = mask_q;
  assign o_Done        = done_q;
  assign o_Pass        = pass_q;
  assign o_Dbg_State   = state_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
module tb_freq_sweep_ctrl;
  import freq_sweep_pkg::*;

  localparam int G  = 400;
  localparam int S  = 16;
  localparam int G2 = 1000;
  localparam int RUN_LEN = 4 * (1 + S + G + 1) + 1;
  localparam int TIMEOUT = 6000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       freq_in;
  logic       freq_out, busy, cnt_valid, done, pass;
  logic [1:0] step;
  logic [15:0] count;
  logic [3:0] fail_mask;
  state_t     dbg_state;

  logic       s_start = 1'b0;
  logic       s_freq_out, s_busy, s_valid, s_done, s_pass;
  logic [1:0] s_step;
  logic [7:0] s_count;
  logic [3:0] s_mask;
  state_t     s_state;

  // Stimulus source select: 0 loopback, 1 tied low, 2 external square wave.
  int   mode = 0;
  int   ext_hp = 2;
  int   ext_cnt = 0;
  logic ext_sig = 1'b0;

  assign freq_in = (mode == 0) ? freq_out : (mode == 1) ? 1'b0 : ext_sig;

  freq_sweep_ctrl #(.NUM_STEPS(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S),
                    .CNT_W(16), .DIV_W(8)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Freq_In(freq_in),
    .o_Freq_Out(freq_out), .o_Busy(busy), .o_Step(step), .o_Count(count),
    .o_Count_Valid(cnt_valid), .o_Fail_Mask(fail_mask), .o_Done(done),
    .o_Pass(pass), .o_Dbg_State(dbg_state)
  );

  // Narrow counter instance to exercise saturation.
  freq_sweep_ctrl #(.NUM_STEPS(4), .GATE_CYCLES(G2), .SETTLE_CYCLES(S),
                    .CNT_W(8), .DIV_W(8)) dut_sat (
    .i_Clk(clk), .i_Reset(rst), .i_Start(s_start), .i_Freq_In(s_freq_out),
    .o_Freq_Out(s_freq_out), .o_Busy(s_busy), .o_Step(s_step), .o_Count(s_count),
    .o_Count_Valid(s_valid), .o_Fail_Mask(s_mask), .o_Done(s_done),
    .o_Pass(s_pass), .o_Dbg_State(s_state)
  );

  // External square wave, updated just after the edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (ext_cnt >= ext_hp - 1) begin
      ext_cnt = 0;
      ext_sig = ~ext_sig;
    end else begin
      ext_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int done_count = 0;
  int busy_len = 0;
  int s_idx = 0;
  int s_done_seen = 0;
  int half_ref [4] = '{1, 2, 5, 10};
  logic [15:0] exp_q[$];
  logic [3:0]  exp_mask_q[$];
  logic        exp_pass_q[$];
  int          s_exp [4];
  logic [3:0]  s_exp_mask;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_tol(input string name, input int actual, input int expected);
    int diff;
    n_checks++;
    diff = actual - expected;
    if (diff < -1 || diff > 1) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d +/-1", name, actual, expected);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Monitor for the main instance.
  always @(negedge clk) begin
    if (cnt_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_count", int'(count), -1);
      end else begin
        check_tol("count", int'(count), int'(exp_q.pop_front()));
      end
    end
    if (done) begin
      done_count++;
      check("run_length", busy_len, RUN_LEN);
      busy_len = 0;
      if (exp_mask_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("fail_mask", int'(fail_mask), int'(exp_mask_q.pop_front()));
        check("pass", int'(pass), int'(exp_pass_q.pop_front()));
      end
    end else if (busy) begin
      busy_len++;
    end else begin
      busy_len = 0;
    end
  end

  // Monitor for the saturating instance.
  always @(negedge clk) begin
    if (s_valid) begin
      if (s_idx < 4) check("sat_count", int'(s_count), s_exp[s_idx]);
      else check("sat_extra_count", 1, 0);
      s_idx++;
    end
    if (s_done) begin
      s_done_seen++;
      check("sat_mask", int'(s_mask), int'(s_exp_mask));
      check("sat_pass", int'(s_pass), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model: rising edges in a G-cycle window for the selected source,
  // clipped at the counter ceiling, graded against G/(2H) +/- 1.
  task automatic push_expect(input int m, input int hp);
    logic [3:0] mask;
    int n, e;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      e = G / (2 * half_ref[k]);
      if (m == 0)      n = e;
      else if (m == 1) n = 0;
      else             n = G / (2 * hp);
      if (n > 65535) n = 65535;
      exp_q.push_back(16'(n));
      mask[k] = (iabs(n - e) > 1);
    end
    exp_mask_q.push_back(mask);
    exp_pass_q.push_back(mask == 4'b0000);
  endtask

  task automatic wait_done_from(input int d0);
    int t;
    t = 0;
    while (done_count == d0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) check("done_timeout", 0, 1);
    repeat (40) @(negedge clk);
    check("done_pulses", done_count - d0, 1);
  endtask

  task automatic wait_state(input state_t st, input int stp, input string name);
    int t;
    t = 0;
    while (!(dbg_state == st && int'(step) == stp) && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) check(name, 0, 1);
  endtask

  task automatic run_sweep(input int m, input int hp, input bit extra);
    int d0;
    mode = m;
    ext_hp = hp;
    repeat ($urandom_range(2, 20)) @(negedge clk);
    push_expect(m, hp);
    d0 = done_count;
    pulse_start();
    if (extra) begin
      wait_state(ST_SETTLE, 0, "settle_timeout");
      repeat ($urandom_range(0, S - 3)) @(negedge clk);
      pulse_start();
      wait_state(ST_GATE, 0, "gate_timeout");
      for (int i = 0; i < 3; i++) begin
        repeat ($urandom_range(5, 100)) @(negedge clk);
        pulse_start();
      end
    end
    wait_done_from(d0);
  endtask

  task automatic reset_mid_gate();
    mode = 0;
    push_expect(0, 1);
    pulse_start();
    wait_state(ST_GATE, 2, "step2_timeout");
    repeat ($urandom_range(1, G - 50)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_freq_out", int'(freq_out), 0);
    check("abort_step", int'(step), 0);
    check("abort_mask", int'(fail_mask), 0);
    check("abort_count_valid", int'(cnt_valid), 0);
    // Steps 2 and 3 never complete; their expectations are void.
    exp_q.delete();
    exp_mask_q.delete();
    exp_pass_q.delete();
    repeat (50) @(negedge clk);
    check("abort_still_idle", int'(busy), 0);
  endtask

  // ---------------- saturating-instance driver ----------------
  initial begin
    int n;
    s_exp_mask = '0;
    for (int k = 0; k < 4; k++) begin
      n = G2 / (2 * half_ref[k]);
      s_exp[k] = (n > 255) ? 255 : n;
      s_exp_mask[k] = (iabs(s_exp[k] - n) > 1);
    end
    @(negedge clk);
    while (rst) @(negedge clk);
    repeat (3) @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    repeat (4) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_freq_out", int'(freq_out), 0);
    check("reset_step", int'(step), 0);
    check("reset_count", int'(count), 0);
    check("reset_valid", int'(cnt_valid), 0);
    check("reset_mask", int'(fail_mask), 0);
    check("reset_done", int'(done), 0);
    check("reset_pass", int'(pass), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_sweep(0, 1, 1'b0);
    run_sweep(1, 1, 1'b0);
    run_sweep(2, 2, 1'b0);
    for (int i = 0; i < 2; i++) run_sweep(2, int'($urandom_range(1, 6)), 1'b0);
    reset_mid_gate();
    run_sweep(0, 1, 1'b0);
    run_sweep(0, 1, 1'b1);

    t = 0;
    while (s_done_seen == 0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("sat_done_seen", s_done_seen, 1);
    check("sat_valid_pulses", s_idx, 4);
    check("leftover_counts", exp_q.size(), 0);
    check("leftover_masks", exp_mask_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
